// File: rtl/fpga_state_writer.sv
// Writes firmware version words after reset, then mirrors live FPGA status into the controller BRAM.
// Latency: a status change is presented on the bus 2 cycles after it is seen and commits on grant.
// Backpressure: while bus_gnt is low, request/address/data hold and the sequence stalls.
// Optional build macro STATUS_HEARTBEAT_EN adds a periodic rewrite of the status word.
module fpga_state_writer #(
    parameter logic [7:0] VERSION_MAJOR    = 8'h90,
    parameter logic [7:0] VERSION_MINOR    = 8'h00,
    parameter int         HEARTBEAT_CYCLES = 20480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        thermo,
    input  logic        mod_segment,
    input  logic        stm_segment,
    input  logic        stm_mode,
    input  logic        refresh,
    input  logic        bus_gnt,
    output logic        bus_req,
    output logic        bus_we,
    output logic [7:0]  bus_addr,
    output logic [15:0] bus_din,
    output logic        init_done
);

    localparam logic [7:0] ADDR_FPGA_STATE        = 8'h01;
    localparam logic [7:0] ADDR_VERSION_NUM_MAJOR = 8'h30;
    localparam logic [7:0] ADDR_VERSION_NUM_MINOR = 8'h31;

    typedef enum logic [1:0] {
        INIT_MAJOR,
        INIT_MINOR,
        WR_STATE,
        IDLE
    } state_t;

    state_t      state;
    logic        thermo_meta;
    logic        thermo_sync;
    logic [15:0] state_word;
    logic [15:0] snap;
    logic [15:0] last;
    logic        refresh_pending;
    logic        commit;
    logic        hb_due;
    logic        trigger;

    // Bring the asynchronous thermal-alarm pin into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thermo_meta <= 1'b0;
            thermo_sync <= 1'b0;
        end else begin
            thermo_meta <= thermo;
            thermo_sync <= thermo_meta;
        end
    end

    assign state_word = {12'h000, stm_mode, stm_segment, mod_segment, thermo_sync};
    assign commit     = bus_req & bus_gnt & bus_we;

`ifdef STATUS_HEARTBEAT_EN
    logic [14:0] hb_cnt;

    assign hb_due = (hb_cnt == 15'(HEARTBEAT_CYCLES - 1));

    // Count idle cycles since the last status commit; stop at the due value until the rewrite lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hb_cnt <= '0;
        end else if (state == WR_STATE && commit) begin
            hb_cnt <= '0;
        end else if (state == IDLE && !hb_due) begin
            hb_cnt <= hb_cnt + 15'd1;
        end
    end
`else
    assign hb_due = 1'b0;
`endif

    // last is only compared in IDLE, which is reached only after the first status write has set it.
    assign trigger = (state_word != last) | refresh_pending | hb_due;

    // Write sequencer: version words, then status word, then wait for a change/refresh/heartbeat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= INIT_MAJOR;
            bus_req         <= 1'b0;
            bus_we          <= 1'b0;
            bus_addr        <= 8'h00;
            bus_din         <= 16'h0000;
            init_done       <= 1'b0;
            snap            <= 16'h0000;
            last            <= 16'h0000;
            refresh_pending <= 1'b0;
        end else begin
            // A refresh is remembered in every state; only a snapshot taken from IDLE consumes it.
            refresh_pending <= refresh_pending | refresh;
            case (state)
                INIT_MAJOR: begin
                    if (!bus_req) begin
                        bus_req  <= 1'b1;
                        bus_we   <= 1'b1;
                        bus_addr <= ADDR_VERSION_NUM_MAJOR;
                        bus_din  <= {8'h00, VERSION_MAJOR};
                    end else if (commit) begin
                        state    <= INIT_MINOR;
                        bus_addr <= ADDR_VERSION_NUM_MINOR;
                        bus_din  <= {8'h00, VERSION_MINOR};
                    end
                end
                INIT_MINOR: begin
                    // Request stays high straight into the first, unconditional status write.
                    // A refresh seen during init is deliberately kept so it yields one extra write.
                    if (commit) begin
                        init_done <= 1'b1;
                        state     <= WR_STATE;
                        snap      <= state_word;
                        bus_addr  <= ADDR_FPGA_STATE;
                        bus_din   <= state_word;
                    end
                end
                WR_STATE: begin
                    if (!bus_req) begin
                        // Entered from IDLE: take the snapshot once; it is not retaken while stalled.
                        snap            <= state_word;
                        bus_din         <= state_word;
                        bus_addr        <= ADDR_FPGA_STATE;
                        bus_req         <= 1'b1;
                        bus_we          <= 1'b1;
                        refresh_pending <= refresh;
                    end else if (commit) begin
                        last    <= snap;
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                IDLE: begin
                    if (trigger) begin
                        state <= WR_STATE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_state_writer.sv
// Directed bench for fpga_state_writer with a write scoreboard.
// Expected commits are queued by the stimulus; a negedge monitor pops and compares each commit.
// Timing and stall behaviour are checked from the recorded commit cycles and bus values.
module tb_fpga_state_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        thermo = 1'b0;
    logic        mod_segment = 1'b0;
    logic        stm_segment = 1'b0;
    logic        stm_mode = 1'b0;
    logic        refresh = 1'b0;
    logic        bus_gnt = 1'b1;
    logic        bus_req;
    logic        bus_we;
    logic [7:0]  bus_addr;
    logic [15:0] bus_din;
    logic        init_done;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] din;
        logic        done;
    } wr_t;

    wr_t exp_q[$];
    int  commit_cyc[$];
    int  ncommit = 0;
    int  cyc = 0;
    int  total = 0;
    int  bad = 0;

    fpga_state_writer #(
        .VERSION_MAJOR   (8'h90),
        .VERSION_MINOR   (8'h00),
        .HEARTBEAT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .thermo     (thermo),
        .mod_segment(mod_segment),
        .stm_segment(stm_segment),
        .stm_mode   (stm_mode),
        .refresh    (refresh),
        .bus_gnt    (bus_gnt),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_din    (bus_din),
        .init_done  (init_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic wr_t mk(input logic [7:0] a, input logic [15:0] d, input logic dn);
        wr_t w;
        w.addr = a;
        w.din  = d;
        w.done = dn;
        return w;
    endfunction

    // Scoreboard monitor: every committed write must match the oldest queued expectation.
    always @(negedge clk) begin
        wr_t e;
        if (!rst && bus_req && bus_gnt && bus_we) begin
            ncommit++;
            commit_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: actual addr=%0h din=%0h required no write", bus_addr, bus_din);
            end else begin
                e = exp_q.pop_front();
                check("commit{addr,din,init_done}", {7'd0, bus_addr, bus_din, init_done}, {7'd0, e});
            end
        end
    end

    // Advance to just after the next rising edge (input drive point).
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_commits(input int n, input int max, input string name);
        int k = 0;
        while (ncommit < n && k < max) begin
            tick(1);
            k++;
        end
        check(name, (ncommit >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_present(input logic [7:0] a, input int max, input string name);
        int k = 0;
        while (!(bus_req && bus_addr == a) && k < max) begin
            tick(1);
            k++;
        end
        check(name, {31'd0, bus_req && bus_addr == a}, 32'd1);
    endtask

    initial begin
        int n0;
        int base;

        // Reset state
        tick(3);
        check("rst_req", {31'd0, bus_req}, 0);
        check("rst_we", {31'd0, bus_we}, 0);
        check("rst_addr", {24'd0, bus_addr}, 0);
        check("rst_din", {16'd0, bus_din}, 0);
        check("rst_init_done", {31'd0, init_done}, 0);

        // T1: version words then initial status, three consecutive commits
        exp_q.push_back(mk(8'h30, 16'h0090, 1'b0));
        exp_q.push_back(mk(8'h31, 16'h0000, 1'b0));
        exp_q.push_back(mk(8'h01, 16'h0000, 1'b1));
        rst = 1'b0;
        wait_commits(3, 20, "t1_three_commits");
        check("t1_consecutive", commit_cyc[2] - commit_cyc[0], 2);
        tick(2);
        check("t1_init_done", {31'd0, init_done}, 1);
        check("t1_req_low", {31'd0, bus_req}, 0);

`ifndef STATUS_HEARTBEAT_EN
        // T2: STM_SEGMENT change in cycle N -> request and commit in cycle N+2
        tick(3);
        n0 = ncommit;
        exp_q.push_back(mk(8'h01, 16'h0004, 1'b1));
        stm_segment = 1'b1;
        base = cyc;
        @(negedge clk);
        @(negedge clk);
        check("t2_req_at_n1", {31'd0, bus_req}, 0);
        @(negedge clk);
        check("t2_req_at_n2", {31'd0, bus_req}, 1);
        tick(8);
        check("t2_write_count", ncommit - n0, 1);
        check("t2_commit_cycle", commit_cyc[commit_cyc.size() - 1] - base, 2);

        // T3: THERMO through the synchronizer, commit 4 cycles after the capturing edge
        tick(2);
        n0 = ncommit;
        exp_q.push_back(mk(8'h01, 16'h0005, 1'b1));
        thermo = 1'b1;
        base = cyc;
        tick(10);
        check("t3_write_count", ncommit - n0, 1);
        check("t3_commit_cycle", commit_cyc[commit_cyc.size() - 1] - base, 4);

        // T4: grant withheld during INIT_MINOR; bus holds, later state write sees new MOD_SEGMENT
        rst = 1'b1;
        thermo = 1'b0;
        stm_segment = 1'b0;
        mod_segment = 1'b0;
        tick(2);
        exp_q.push_back(mk(8'h30, 16'h0090, 1'b0));
        exp_q.push_back(mk(8'h31, 16'h0000, 1'b0));
        exp_q.push_back(mk(8'h01, 16'h0002, 1'b1));
        rst = 1'b0;
        wait_present(8'h31, 10, "t4_reach_minor");
        bus_gnt = 1'b0;
        n0 = ncommit;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_hold{req,addr,din}", {7'd0, bus_req, bus_addr, bus_din}, {7'd0, 1'b1, 8'h31, 16'h0000});
            if (i == 2 || i == 5 || i == 7) mod_segment = ~mod_segment;
        end
        check("t4_no_commit", ncommit - n0, 0);
        tick(1);
        bus_gnt = 1'b1;
        wait_commits(n0 + 2, 10, "t4_resume");
        tick(3);

        // T5: refresh while WR_STATE is stalled -> exactly two identical writes
        n0 = ncommit;
        exp_q.push_back(mk(8'h01, 16'h0002, 1'b1));
        exp_q.push_back(mk(8'h01, 16'h0002, 1'b1));
        bus_gnt = 1'b0;
        refresh = 1'b1;
        tick(1);
        refresh = 1'b0;
        wait_present(8'h01, 10, "t5_in_wr_state");
        refresh = 1'b1;
        tick(1);
        refresh = 1'b0;
        tick(2);
        bus_gnt = 1'b1;
        tick(15);
        check("t5_write_count", ncommit - n0, 2);

        // T5b: reset mid-INIT aborts without committing, then restarts at the major version word
        rst = 1'b1;
        tick(1);
        exp_q.push_back(mk(8'h30, 16'h0090, 1'b0));
        rst = 1'b0;
        wait_present(8'h31, 10, "t5b_reach_minor");
        bus_gnt = 1'b0;
        tick(2);
        rst = 1'b1;
        #1;
        check("t5b_rst_outputs", {7'd0, bus_req, bus_we, bus_addr, bus_din, init_done},
              32'd0);
        tick(1);
        exp_q.push_back(mk(8'h30, 16'h0090, 1'b0));
        exp_q.push_back(mk(8'h31, 16'h0000, 1'b0));
        exp_q.push_back(mk(8'h01, 16'h0002, 1'b1));
        n0 = ncommit;
        bus_gnt = 1'b1;
        rst = 1'b0;
        wait_commits(n0 + 3, 20, "t5b_restart");

        // T6 (no heartbeat): static inputs produce no rewrite for 1000 cycles
        tick(3);
        n0 = ncommit;
        tick(1000);
        check("t6_no_rewrite", ncommit - n0, 0);
`else
        // T6 (heartbeat, 16 cycles): static status rewritten after every 16 idle cycles.
        // Spacing between commits is 16 idle cycles + 1 cycle entering WR_STATE + 1 commit cycle.
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(8'h01, 16'h0000, 1'b1));
        n0 = ncommit;
        wait_commits(n0 + 4, 120, "t6_heartbeats");
        for (int i = 2; i < 6; i++) begin
            check("t6_hb_spacing", commit_cyc[i + 1] - commit_cyc[i], 18);
        end
`endif

        check("all_expected_written", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
